// File: rtl/img_mem_responder_if.sv
// Bus bundle for img_mem_responder: image load stream, read-address stream and read-data stream.
// The master side is the frame source / data fetcher, the slave side is the responder.
interface img_mem_responder_if #(
    parameter int W_DATA = 8,
    parameter int W_ADDR = 12
);
    logic              wr_valid;
    logic              wr_ready;
    logic [W_DATA-1:0] wr_data;
    logic              restart;
    logic              load_done;
    logic              addr_valid;
    logic              addr_ready;
    logic [W_ADDR-1:0] addr;
    logic              dout_valid;
    logic              dout_ready;
    logic [W_DATA-1:0] dout_data;
    logic              addr_err;

    modport master (
        output wr_valid, wr_data, restart, addr_valid, addr, dout_ready,
        input  wr_ready, load_done, addr_ready, dout_valid, dout_data, addr_err
    );

    modport slave (
        input  wr_valid, wr_data, restart, addr_valid, addr, dout_ready,
        output wr_ready, load_done, addr_ready, dout_valid, dout_data, addr_err
    );
endinterface

// File: rtl/img_mem_responder.sv
// Image-memory responder: loads a raster image into single-port RAM, then serves in-order reads
// with fixed 2-cycle latency through a credit-limited return FIFO. Optional range check: IMG_MEM_ADDR_CHECK_EN.
module img_mem_responder #(
    parameter int W_DATA     = 8,
    parameter int IMG_WIDTH  = 41,
    parameter int IMG_HEIGHT = 50,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    img_mem_responder_if.slave bus
);
    localparam int N_PIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int W_ADDR = $clog2(N_PIX);
    localparam int W_AX   = W_ADDR + 1;
    localparam int W_PTR  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int W_CNT  = $clog2(FIFO_DEPTH + 1);
    localparam int W_OCC  = W_CNT + 1;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [W_ADDR-1:0]   wr_cnt_r;
    logic [W_ADDR-1:0]   wr_cnt_nxt_s;
    logic [W_DATA-1:0]   mem_r [N_PIX];
    logic [W_DATA-1:0]   ram_q_r;
    logic                rd_vld_r;
    logic [W_DATA-1:0]   fifo_mem_r [FIFO_DEPTH];
    logic [W_PTR-1:0]    wr_ptr_r;
    logic [W_PTR-1:0]    rd_ptr_r;
    logic [W_CNT-1:0]    fifo_cnt_r;
    logic [W_CNT-1:0]    fifo_cnt_nxt_s;
    logic [W_OCC-1:0]    occ_nxt_s;
    logic [W_DATA-1:0]   push_data_s;
    logic                wr_ready_r;
    logic                load_done_r;
    logic                addr_ready_r;
    logic                dout_valid_r;
    logic                wr_fire_s;
    logic                rd_fire_s;
    logic                last_wr_s;
    logic                push_s;
    logic                pop_s;

    function automatic logic [W_PTR-1:0] ptr_inc(input logic [W_PTR-1:0] p);
        return (p == W_PTR'(FIFO_DEPTH - 1)) ? W_PTR'(0) : p + W_PTR'(1);
    endfunction

    // A restart in the same cycle as a load beat wins: the beat is dropped and the count cleared.
    assign wr_fire_s = bus.wr_valid & wr_ready_r & ~bus.restart;
    assign rd_fire_s = bus.addr_valid & addr_ready_r;
    assign last_wr_s = wr_fire_s & (wr_cnt_r == W_ADDR'(N_PIX - 1));
    assign push_s    = rd_vld_r;
    assign pop_s     = dout_valid_r & bus.dout_ready;

    // Next-state and load-counter logic.
    always_comb begin
        state_nxt_s  = state_r;
        wr_cnt_nxt_s = wr_cnt_r;
        case (state_r)
            ST_LOAD: begin
                if (bus.restart) begin
                    wr_cnt_nxt_s = '0;
                end else if (last_wr_s) begin
                    state_nxt_s  = ST_SERVE;
                    wr_cnt_nxt_s = '0;
                end else if (wr_fire_s) begin
                    wr_cnt_nxt_s = wr_cnt_r + W_ADDR'(1);
                end else begin
                    wr_cnt_nxt_s = wr_cnt_r;
                end
            end
            ST_SERVE: begin
                if (bus.restart) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_SERVE;
                end
            end
            ST_DRAIN: begin
                if (!rd_vld_r && (fifo_cnt_r == W_CNT'(0))) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s  = ST_LOAD;
                wr_cnt_nxt_s = '0;
            end
        endcase
    end

    // Return-FIFO occupancy update.
    always_comb begin
        fifo_cnt_nxt_s = fifo_cnt_r;
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + W_CNT'(1);
            2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - W_CNT'(1);
            default: fifo_cnt_nxt_s = fifo_cnt_r;
        endcase
    end

    // Credits: a read in the RAM stage plus FIFO entries must never exceed the FIFO depth.
    assign occ_nxt_s = W_OCC'(rd_fire_s) + W_OCC'(fifo_cnt_nxt_s);

    // State and load-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_LOAD;
            wr_cnt_r <= '0;
        end else begin
            state_r  <= state_nxt_s;
            wr_cnt_r <= wr_cnt_nxt_s;
        end
    end

    // Single-port image RAM: load writes and serve reads never occur in the same state.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_r[wr_cnt_r] <= bus.wr_data;
        end else if (rd_fire_s) begin
            ram_q_r <= mem_r[bus.addr];
        end
    end

    // RAM read stage valid; one cycle after the address handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld_r <= 1'b0;
        end else begin
            rd_vld_r <= rd_fire_s;
        end
    end

`ifdef IMG_MEM_ADDR_CHECK_EN
    logic oob_s;
    logic rd_oob_r;
    logic addr_err_r;

    assign oob_s = ({1'b0, bus.addr} >= W_AX'(N_PIX));

    // Out-of-range reads still return an in-order beat, forced to zero, and raise a sticky flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_oob_r   <= 1'b0;
            addr_err_r <= 1'b0;
        end else begin
            rd_oob_r <= rd_fire_s & oob_s;
            if (bus.restart) begin
                addr_err_r <= 1'b0;
            end else if (rd_fire_s && oob_s) begin
                addr_err_r <= 1'b1;
            end else begin
                addr_err_r <= addr_err_r;
            end
        end
    end

    assign push_data_s  = rd_oob_r ? W_DATA'(0) : ram_q_r;
    assign bus.addr_err = addr_err_r;
`else
    assign push_data_s  = ram_q_r;
    assign bus.addr_err = 1'b0;
`endif

    // Return FIFO storage and pointers; storage reset so dout_data reads 0 out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            fifo_cnt_r <= fifo_cnt_nxt_s;
        end
    end

    // Handshake and status outputs, registered from next-state values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ready_r   <= 1'b0;
            load_done_r  <= 1'b0;
            addr_ready_r <= 1'b0;
            dout_valid_r <= 1'b0;
        end else begin
            wr_ready_r   <= (state_nxt_s == ST_LOAD);
            load_done_r  <= (state_nxt_s != ST_LOAD);
            addr_ready_r <= (state_nxt_s == ST_SERVE) && (occ_nxt_s < W_OCC'(FIFO_DEPTH));
            dout_valid_r <= (fifo_cnt_nxt_s != W_CNT'(0));
        end
    end

    assign bus.wr_ready   = wr_ready_r;
    assign bus.load_done  = load_done_r;
    assign bus.addr_ready = addr_ready_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.dout_data  = fifo_mem_r[rd_ptr_r];
endmodule

// File: tb/tb_img_mem_responder.sv
// Self-checking bench for img_mem_responder: image model plus an in-order expected-data queue.
module tb_img_mem_responder;
    localparam int N_PIX = 41 * 50;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   cyc;

    logic [7:0] img [N_PIX];
    logic [8:0] exp_q [$];  // bit 8: data must match, bits 7:0: expected pixel

    img_mem_responder_if #(.W_DATA(8), .W_ADDR(12)) bus ();

    img_mem_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_data = 8'h00; bus.restart = 1'b0;
        bus.addr_valid = 1'b0; bus.addr = 12'h000; bus.dout_ready = 1'b0;
        step(); step();
        n_vec++; if (bus.wr_ready !== 1'b0) begin n_err++; $display("FAIL rst_wr_ready: got %b expected 0", bus.wr_ready); end
        n_vec++; if (bus.load_done !== 1'b0) begin n_err++; $display("FAIL rst_load_done: got %b expected 0", bus.load_done); end
        n_vec++; if (bus.addr_ready !== 1'b0) begin n_err++; $display("FAIL rst_addr_ready: got %b expected 0", bus.addr_ready); end
        n_vec++; if (bus.dout_valid !== 1'b0) begin n_err++; $display("FAIL rst_dout_valid: got %b expected 0", bus.dout_valid); end
        n_vec++; if (bus.dout_data !== 8'h00) begin n_err++; $display("FAIL rst_dout_data: got %02h expected 00", bus.dout_data); end
        n_vec++; if (bus.addr_err !== 1'b0) begin n_err++; $display("FAIL rst_addr_err: got %b expected 0", bus.addr_err); end
        rst = 1'b1;
        step();
        n_vec++; if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL rel_wr_ready: got %b expected 1", bus.wr_ready); end
        n_vec++; if (bus.addr_ready !== 1'b0) begin n_err++; $display("FAIL rel_addr_ready: got %b expected 0", bus.addr_ready); end
    endtask

    task automatic test_load(input bit invert);
        int cnt;
        int guard;
        cnt = 0;
        guard = 0;
        while (cnt < N_PIX && guard < 20000) begin
            bus.wr_valid = ($urandom_range(0, 3) != 0);
            bus.wr_data  = invert ? (8'hFF - 8'(cnt)) : 8'(cnt);
            if (bus.wr_valid && bus.wr_ready) begin
                img[cnt] = bus.wr_data;
                cnt++;
                if (cnt == N_PIX) begin
                    n_vec++;
                    if (bus.load_done !== 1'b0) begin n_err++; $display("FAIL load_done_early: got %b expected 0", bus.load_done); end
                end
            end
            step();
            guard++;
        end
        bus.wr_valid = 1'b0;
        n_vec++; if (cnt != N_PIX) begin n_err++; $display("FAIL load_timeout: got %0d writes expected %0d", cnt, N_PIX); end
        n_vec++; if (bus.load_done !== 1'b1) begin n_err++; $display("FAIL load_done: got %b expected 1", bus.load_done); end
        n_vec++; if (bus.wr_ready !== 1'b0) begin n_err++; $display("FAIL load_wr_ready: got %b expected 0", bus.wr_ready); end
        step();
        n_vec++; if (bus.wr_ready !== 1'b0) begin n_err++; $display("FAIL load_wr_ready_hold: got %b expected 0", bus.wr_ready); end
    endtask

    task automatic test_back_to_back();
        int addrs[5] = '{0, 1, 40, 41, 2049};
        int idx, got, guard, hs0;
        logic [8:0] e;
        idx = 0; got = 0; guard = 0; hs0 = -1;
        bus.dout_ready = 1'b1;
        while (got < 5 && guard < 60) begin
            bus.addr_valid = (idx < 5);
            bus.addr       = (idx < 5) ? 12'(addrs[idx]) : 12'h000;
            if (bus.addr_valid && bus.addr_ready) begin
                if (idx == 0) hs0 = cyc;
                exp_q.push_back({1'b1, img[addrs[idx]]});
                idx++;
            end
            if (bus.dout_valid && bus.dout_ready) begin
                n_vec++;
                if (cyc != hs0 + 2 + got) begin n_err++; $display("FAIL b2b_timing: got cycle %0d expected %0d", cyc, hs0 + 2 + got); end
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++; $display("FAIL b2b_extra: got %02h expected no beat", bus.dout_data);
                end else begin
                    e = exp_q.pop_front();
                    n_vec++;
                    if (bus.dout_data !== e[7:0]) begin n_err++; $display("FAIL b2b_data: got %02h expected %02h", bus.dout_data, e[7:0]); end
                end
                got++;
            end
            step();
            guard++;
        end
        bus.addr_valid = 1'b0;
        n_vec++; if (got != 5) begin n_err++; $display("FAIL b2b_count: got %0d expected 5", got); end
    endtask

    task automatic test_stall();
        int acc, got, guard;
        logic [7:0] held;
        bit   have;
        logic [8:0] e;
        acc = 0; got = 0; have = 1'b0; held = 8'h00;
        bus.dout_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bus.addr_valid = 1'b1;
            bus.addr       = 12'(100 + 7 * acc);
            if (bus.addr_valid && bus.addr_ready) begin
                exp_q.push_back({1'b1, img[100 + 7 * acc]});
                acc++;
            end
            if (bus.dout_valid) begin
                if (have) begin
                    n_vec++;
                    if (bus.dout_data !== held) begin n_err++; $display("FAIL stall_hold: got %02h expected %02h", bus.dout_data, held); end
                end else begin
                    held = bus.dout_data;
                    have = 1'b1;
                end
            end
            step();
        end
        bus.addr_valid = 1'b0;
        n_vec++; if (acc != 4) begin n_err++; $display("FAIL stall_accepted: got %0d expected 4", acc); end
        bus.dout_ready = 1'b1;
        guard = 0;
        while (guard < 20) begin
            if (bus.dout_valid && bus.dout_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++; $display("FAIL stall_extra: got %02h expected no beat", bus.dout_data);
                end else begin
                    e = exp_q.pop_front();
                    n_vec++;
                    if (bus.dout_data !== e[7:0]) begin n_err++; $display("FAIL stall_data: got %02h expected %02h", bus.dout_data, e[7:0]); end
                end
                got++;
            end
            step();
            guard++;
        end
        n_vec++; if (got != 4) begin n_err++; $display("FAIL stall_returned: got %0d expected 4", got); end
        n_vec++; if (bus.dout_valid !== 1'b0) begin n_err++; $display("FAIL stall_idle: got %b expected 0", bus.dout_valid); end
    endtask

    task automatic test_restart();
        int acc, got, guard, drain_acc;
        logic [8:0] e;
        acc = 0; got = 0; guard = 0; drain_acc = 0;
        bus.dout_ready = 1'b0;
        while (acc < 2 && guard < 20) begin
            bus.addr_valid = 1'b1;
            bus.addr       = 12'(10 + acc);
            if (bus.addr_ready) begin
                exp_q.push_back({1'b1, img[10 + acc]});
                acc++;
            end
            step();
            guard++;
        end
        bus.addr_valid = 1'b0;
        bus.restart    = 1'b1;
        step();
        bus.restart    = 1'b0;
        bus.dout_ready = 1'b1;
        guard = 0;
        while (!(got == 2 && bus.wr_ready) && guard < 40) begin
            bus.addr_valid = 1'b1;
            bus.addr       = 12'd20;
            if (bus.addr_ready) begin
                drain_acc++;
                exp_q.push_back({1'b1, img[20]});
            end
            if (bus.dout_valid && bus.dout_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++; $display("FAIL restart_extra: got %02h expected no beat", bus.dout_data);
                end else begin
                    e = exp_q.pop_front();
                    n_vec++;
                    if (bus.dout_data !== e[7:0]) begin n_err++; $display("FAIL restart_data: got %02h expected %02h", bus.dout_data, e[7:0]); end
                end
                got++;
            end
            step();
            guard++;
        end
        bus.addr_valid = 1'b0;
        n_vec++; if (got != 2) begin n_err++; $display("FAIL restart_returned: got %0d expected 2", got); end
        n_vec++; if (drain_acc != 0) begin n_err++; $display("FAIL restart_drain_accept: got %0d expected 0", drain_acc); end
        n_vec++; if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL restart_wr_ready: got %b expected 1", bus.wr_ready); end
        n_vec++; if (bus.load_done !== 1'b0) begin n_err++; $display("FAIL restart_load_done: got %b expected 0", bus.load_done); end
        test_load(1'b1);
        got = 0; guard = 0; acc = 0;
        while (got < 1 && guard < 20) begin
            bus.addr_valid = (acc == 0);
            bus.addr       = 12'd5;
            if (bus.addr_valid && bus.addr_ready) begin
                exp_q.push_back({1'b1, img[5]});
                acc++;
            end
            if (bus.dout_valid && bus.dout_ready) begin
                e = exp_q.pop_front();
                n_vec++;
                if (bus.dout_data !== e[7:0]) begin n_err++; $display("FAIL reload_data: got %02h expected %02h", bus.dout_data, e[7:0]); end
                got++;
            end
            step();
            guard++;
        end
        bus.addr_valid = 1'b0;
        n_vec++; if (got != 1) begin n_err++; $display("FAIL reload_returned: got %0d expected 1", got); end
    endtask

    task automatic test_reset_midstream();
        int acc, guard;
        acc = 0; guard = 0;
        bus.dout_ready = 1'b0;
        while (acc < 3 && guard < 20) begin
            bus.addr_valid = 1'b1;
            bus.addr       = 12'(acc);
            if (bus.addr_ready) begin
                exp_q.push_back({1'b1, img[acc]});
                acc++;
            end
            step();
            guard++;
        end
        bus.addr_valid = 1'b0;
        step(); step();
        n_vec++; if (bus.dout_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b expected 1", bus.dout_valid); end
        rst = 1'b0;
        #1;
        n_vec++; if (bus.dout_valid !== 1'b0) begin n_err++; $display("FAIL mid_dout_valid: got %b expected 0", bus.dout_valid); end
        n_vec++; if (bus.load_done !== 1'b0) begin n_err++; $display("FAIL mid_load_done: got %b expected 0", bus.load_done); end
        n_vec++; if (bus.addr_ready !== 1'b0) begin n_err++; $display("FAIL mid_addr_ready: got %b expected 0", bus.addr_ready); end
        exp_q.delete();
        step();
        rst = 1'b1;
        step();
        n_vec++; if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL mid_wr_ready: got %b expected 1", bus.wr_ready); end
        n_vec++; if (bus.dout_valid !== 1'b0) begin n_err++; $display("FAIL mid_post_valid: got %b expected 0", bus.dout_valid); end
    endtask

    task automatic test_addr_range();
        int addrs[2] = '{2050, 3};
        int idx, got, guard, hs0;
        logic exp_err;
        logic [8:0] e;
`ifdef IMG_MEM_ADDR_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        test_load(1'b0);
        idx = 0; got = 0; guard = 0; hs0 = -10;
        bus.dout_ready = 1'b1;
        while (got < 2 && guard < 30) begin
            bus.addr_valid = (idx < 2);
            bus.addr       = (idx < 2) ? 12'(addrs[idx]) : 12'h000;
            if (cyc == hs0 + 1) begin
                n_vec++;
                if (bus.addr_err !== exp_err) begin n_err++; $display("FAIL range_err_set: got %b expected %b", bus.addr_err, exp_err); end
            end
            if (bus.addr_valid && bus.addr_ready) begin
                if (idx == 0) begin
                    hs0 = cyc;
                    n_vec++;
                    if (bus.addr_err !== 1'b0) begin n_err++; $display("FAIL range_err_early: got %b expected 0", bus.addr_err); end
                    exp_q.push_back({exp_err, 8'h00});
                end else begin
                    exp_q.push_back({1'b1, img[addrs[idx]]});
                end
                idx++;
            end
            if (bus.dout_valid && bus.dout_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++; $display("FAIL range_extra: got %02h expected no beat", bus.dout_data);
                end else begin
                    e = exp_q.pop_front();
                    if (e[8]) begin
                        n_vec++;
                        if (bus.dout_data !== e[7:0]) begin n_err++; $display("FAIL range_data: got %02h expected %02h", bus.dout_data, e[7:0]); end
                    end
                end
                got++;
            end
            step();
            guard++;
        end
        bus.addr_valid = 1'b0;
        step(); step();
        n_vec++; if (got != 2) begin n_err++; $display("FAIL range_returned: got %0d expected 2", got); end
        n_vec++; if (bus.addr_err !== exp_err) begin n_err++; $display("FAIL range_err_sticky: got %b expected %b", bus.addr_err, exp_err); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        test_reset();
        test_load(1'b0);
        test_back_to_back();
        test_stall();
        test_restart();
        test_reset_midstream();
        test_addr_range();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
